// File: rtl/vc_arbiter.sv
// Two-VC arbiter: pops VC0/VC1 with VC0 priority plus a burst cap, and routes each
// word to D0/D1 by its destination bit through a two-stage pop->push pipeline.
module vc_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [DATA_WIDTH-1:0] head_vc0,
  input  logic [DATA_WIDTH-1:0] head_vc1,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  input  logic                  full_d0,
  input  logic                  full_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle,
  output logic                  error
);
  localparam int STAGES = 2;
  localparam int BW     = 4;

  typedef enum logic [1:0] {INIT, IDLE, ACTIVE} state_t;

  state_t                  state, state_nxt;
  logic [BW-1:0]           burst, burst_nxt;
  logic [STAGES:1]         vld_pipe;
  logic                    sel_vc1;
  logic                    popped0, popped1;
  logic                    run, elig0, elig1, grant0, grant1;
  logic [DATA_WIDTH-1:0]   cap;
  logic                    unused_ok;

  // Only the destination bit of the head peek matters here.
  assign unused_ok = ^{head_vc0, head_vc1};

  assign run   = init && (state != INIT);
  // A VC just popped still shows its old head for one cycle, so it sits out.
  assign elig0 = run && !empty_vc0 && !popped0 &&
                 !(head_vc0[DEST_BIT] ? almost_full_d1 : almost_full_d0);
  assign elig1 = run && !empty_vc1 && !popped1 &&
                 !(head_vc1[DEST_BIT] ? almost_full_d1 : almost_full_d0);

  assign grant0  = elig0 && (!elig1 || burst < BW'(BURST_MAX));
  assign grant1  = elig1 && !grant0;
  assign pop_vc0 = grant0;
  assign pop_vc1 = grant1;

  assign cap = sel_vc1 ? data_vc1 : data_vc0;

  always_comb begin
    burst_nxt = burst;
    if (grant0 && elig1)
      burst_nxt = (burst < BW'(BURST_MAX)) ? burst + 1'b1 : burst;
    else if (grant1 || !elig1)
      burst_nxt = '0;

    state_nxt = state;
    case (state)
      INIT:    state_nxt = IDLE;
      IDLE:    if (elig0 || elig1) state_nxt = ACTIVE;
      ACTIVE:  if (!elig0 && !elig1 && vld_pipe == '0) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
    if (!init) state_nxt = INIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      burst    <= '0;
      vld_pipe <= '0;
      sel_vc1  <= 1'b0;
      popped0  <= 1'b0;
      popped1  <= 1'b0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_out <= '0;
      idle     <= 1'b1;
      error    <= 1'b0;
    end else if (!init) begin
      // Dropping init discards in-flight words and clears the sticky error.
      state    <= INIT;
      burst    <= '0;
      vld_pipe <= '0;
      sel_vc1  <= 1'b0;
      popped0  <= 1'b0;
      popped1  <= 1'b0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_out <= '0;
      idle     <= 1'b1;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      burst    <= burst_nxt;
      popped0  <= grant0;
      popped1  <= grant1;
      vld_pipe <= {vld_pipe[1], grant0 | grant1};
      sel_vc1  <= grant1;
      push_d0  <= vld_pipe[1] && !cap[DEST_BIT];
      push_d1  <= vld_pipe[1] &&  cap[DEST_BIT];
      data_out <= vld_pipe[1] ? cap : '0;
      idle     <= (state_nxt != ACTIVE);
      error    <= error | (push_d0 & full_d0) | (push_d1 & full_d1);
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomized bench for vc_arbiter: the bench plays the VC FIFOs as queues and
// predicts pops and pushes from the arbitration rules each cycle.
module tb_vc_arbiter;
  localparam int DW   = 6;
  localparam int DB   = 4;
  localparam int BMAX = 4;

  logic          clk = 1'b0;
  logic          reset, init, empty_vc0, empty_vc1;
  logic [DW-1:0] head_vc0, head_vc1, data_vc0, data_vc1, data_out;
  logic          almost_full_d0, almost_full_d1, full_d0, full_d1;
  logic          pop_vc0, pop_vc1, push_d0, push_d1, idle, error;

  always #5 clk = ~clk;

  vc_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DB), .BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .head_vc0(head_vc0), .head_vc1(head_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
    .full_d0(full_d0), .full_d1(full_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .idle(idle), .error(error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // FIFO contents and the reference model
  logic [DW-1:0] q0[$], q1[$];
  int            m_state;  // 0 init, 1 idle, 2 active
  int            m_burst;
  bit            m_prev0, m_prev1, s1_vld, m_p0, m_p1, m_idle, m_err;
  logic [DW-1:0] s1_word, m_data;
  bit            rd0_vld, rd1_vld;
  logic [DW-1:0] rd0_word, rd1_word;

  task automatic model_clear();
    m_state = 0; m_burst = 0; m_prev0 = 0; m_prev1 = 0;
    s1_vld = 0; s1_word = '0; m_p0 = 0; m_p1 = 0; m_data = '0;
    m_idle = 1; m_err = 0;
  endtask

  task automatic step(input bit rst_v, input bit init_v, input bit af0_v, input bit af1_v,
                      input bit f0_v, input bit f1_v);
    bit run, e0, e1, g0, g1, old_s1v, old_push;
    int nxt;
    @(negedge clk);
    reset = rst_v; init = init_v;
    almost_full_d0 = af0_v; almost_full_d1 = af1_v;
    full_d0 = f0_v; full_d1 = f1_v;
    empty_vc0 = (q0.size() == 0);
    empty_vc1 = (q1.size() == 0);
    head_vc0  = empty_vc0 ? DW'($urandom) : q0[0];
    head_vc1  = empty_vc1 ? DW'($urandom) : q1[0];
    data_vc0  = rd0_vld ? rd0_word : DW'($urandom);
    data_vc1  = rd1_vld ? rd1_word : DW'($urandom);
    if (!rst_v) model_clear();
    #1;
    run = rst_v && init_v && (m_state != 0);
    e0 = 0; e1 = 0;
    if (run && q0.size() > 0) e0 = !m_prev0 && !(q0[0][DB] ? af1_v : af0_v);
    if (run && q1.size() > 0) e1 = !m_prev1 && !(q1[0][DB] ? af1_v : af0_v);
    g0 = e0 && (!e1 || m_burst < BMAX);
    g1 = e1 && !g0;
    chk("pop_vc0",  pop_vc0,  g0);
    chk("pop_vc1",  pop_vc1,  g1);
    chk("push_d0",  push_d0,  m_p0);
    chk("push_d1",  push_d1,  m_p1);
    chk("data_out", data_out, m_data);
    chk("idle",     idle,     m_idle);
    chk("error",    error,    m_err);
    @(posedge clk);
    rd0_vld = 0; rd1_vld = 0;
    if (rst_v) begin
      if (g0) begin rd0_vld = 1; rd0_word = q0.pop_front(); end
      if (g1) begin rd1_vld = 1; rd1_word = q1.pop_front(); end
      if (!init_v) model_clear();
      else begin
        old_s1v  = s1_vld;
        old_push = m_p0 | m_p1;
        if ((m_p0 && f0_v) || (m_p1 && f1_v)) m_err = 1;
        if (s1_vld) begin
          m_data = s1_word; m_p1 = s1_word[DB]; m_p0 = !s1_word[DB];
        end else begin
          m_data = '0; m_p0 = 0; m_p1 = 0;
        end
        s1_vld  = g0 | g1;
        s1_word = g0 ? rd0_word : rd1_word;
        m_prev0 = g0; m_prev1 = g1;
        if (g0 && e1) m_burst = (m_burst < BMAX) ? m_burst + 1 : BMAX;
        else if (g1 || !e1) m_burst = 0;
        case (m_state)
          0:       nxt = 1;
          1:       nxt = (e0 || e1) ? 2 : 1;
          default: nxt = (!e0 && !e1 && !old_s1v && !old_push) ? 1 : 2;
        endcase
        m_state = nxt;
        m_idle  = (nxt != 2);
      end
    end
  endtask

  initial begin
    reset = 0; init = 0; empty_vc0 = 1; empty_vc1 = 1;
    head_vc0 = '0; head_vc1 = '0; data_vc0 = '0; data_vc1 = '0;
    almost_full_d0 = 0; almost_full_d1 = 0; full_d0 = 0; full_d1 = 0;
    rd0_vld = 0; rd1_vld = 0; rd0_word = '0; rd1_word = '0;
    model_clear();

    // reset, init held low, then init with both VCs empty
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);

    // routing by destination bit
    q0.push_back(6'h10); q0.push_back(6'h05);
    repeat (8) step(1, 1, 0, 0, 0, 0);

    // both VCs loaded, no backpressure
    repeat (10) begin q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom)); end
    repeat (24) step(1, 1, 0, 0, 0, 0);

    // VC1 held off by D1 almost-full for 6 cycles, then released
    repeat (12) q0.push_back(DW'($urandom) & 6'h2F);
    repeat (6)  q1.push_back(DW'($urandom) | 6'h10);
    repeat (6)  step(1, 1, 0, 1, 0, 0);
    repeat (24) step(1, 1, 0, 0, 0, 0);

    // backpressure on D1 stalls VC0 (head to D1) while VC1 (head to D0) proceeds
    q0.delete(); q1.delete();
    q0.push_back(6'h10); q1.push_back(6'h02); q1.push_back(6'h03);
    repeat (4) step(1, 1, 0, 1, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0, 0);

    // push into a full D0 sets a sticky error; init low clears it
    q0.push_back(6'h01);
    repeat (4) step(1, 1, 0, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0, 0);

    // async reset between pop and push loses the word
    q0.push_back(6'h11);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0, 0);

    // randomized traffic with backpressure, full flags, init drops and resets
    repeat (3000) begin
      if ($urandom_range(0, 2) != 0 && q0.size() < 8) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) != 0 && q1.size() < 8) q1.push_back(DW'($urandom));
      step($urandom_range(0, 299) != 0, $urandom_range(0, 79) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
